// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: 8-phase cycle per instruction, opcode/zero decode to datapath strobes.
// Latency: strobes are combinational from the registered phase (valid one edge after the phase is entered); 8 cycles per instruction.
// Backpressure: none; the sequencer free-runs one phase per clock (optionally freezes on HLT when CTRL_HALT_LATCH_EN is defined).
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   opcode[2:0], zero  : IR opcode field and accumulator-zero flag (must be stable from INST_LOAD onward)
//   sel                : address mux select, 1 = PC, 0 = IR operand address
//   mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e : datapath strobes
//   halt               : HLT decoded (pulse) or sticky halt when CTRL_HALT_LATCH_EN is defined
//   instr_cnt          : retired-instruction counter, wraps modulo 2^CNT_W
//
// Build option: CTRL_HALT_LATCH_EN makes HLT sticky, freezing the sequencer until rst.
module cpu_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             sel,
    output logic             mem_rd,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ac,
    output logic             mem_wr,
    output logic             data_e,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_halted;
    logic             w_is_hlt;
    logic             w_is_aluop;

    assign w_is_hlt   = (opcode == OP_HLT);
    assign w_is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef CTRL_HALT_LATCH_EN
    logic r_halt;
    assign w_halted = r_halt;
`else
    assign w_halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= INST_ADDR;
            r_instr_cnt <= '0;
`ifdef CTRL_HALT_LATCH_EN
            r_halt      <= 1'b0;
`endif
        end else begin
            r_phase <= w_phase_nxt;
            // A halted sequencer never reaches STORE, so the counter stops with it.
            if (r_phase == STORE) begin
                r_instr_cnt <= r_instr_cnt + CNT_ONE;
            end
`ifdef CTRL_HALT_LATCH_EN
            if (r_phase == OP_ADDR && w_is_hlt) begin
                r_halt <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_phase_nxt = phase_t'(r_phase + 3'd1);
        sel         = 1'b0;
        mem_rd      = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_ac     = 1'b0;
        mem_wr      = 1'b0;
        data_e      = 1'b0;
        halt        = 1'b0;

        // Frozen at OP_FETCH once the halt latch is set.
        if (w_halted) begin
            w_phase_nxt = r_phase;
        end

        case (r_phase)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = w_is_hlt;
            end
            OP_FETCH: begin
                mem_rd = w_is_aluop;
            end
            ALU_OP: begin
                mem_rd  = w_is_aluop;
                load_ac = w_is_aluop;
                inc_pc  = (opcode == OP_SKZ) && zero;
                load_pc = (opcode == OP_JMP);
                data_e  = (opcode == OP_STO);
            end
            STORE: begin
                mem_rd  = w_is_aluop;
                load_ac = w_is_aluop;
                inc_pc  = (opcode == OP_JMP);
                load_pc = (opcode == OP_JMP);
                mem_wr  = (opcode == OP_STO);
                data_e  = (opcode == OP_STO);
            end
            default: begin
                sel = 1'b1;
            end
        endcase

        if (w_halted) begin
            sel     = 1'b0;
            mem_rd  = 1'b0;
            load_ir = 1'b0;
            inc_pc  = 1'b0;
            load_pc = 1'b0;
            load_ac = 1'b0;
            mem_wr  = 1'b0;
            data_e  = 1'b0;
            halt    = 1'b1;
        end

        // While reset is held the bus points at the PC and nothing else moves,
        // independent of where the phase register happens to be.
        if (rst) begin
            sel     = 1'b1;
            mem_rd  = 1'b0;
            load_ir = 1'b0;
            inc_pc  = 1'b0;
            load_pc = 1'b0;
            load_ac = 1'b0;
            mem_wr  = 1'b0;
            data_e  = 1'b0;
            halt    = 1'b0;
        end
    end

    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: directed instruction sequences, scoreboard queue of per-cycle expected outputs.
// Latency: one expected entry per clock, checked on the falling edge of that cycle.
// Backpressure: none; monitor pops whenever an entry is pending.
module tb_cpu_ctrl;

    localparam logic [8:0] S_SEL = 9'h100;
    localparam logic [8:0] S_RD  = 9'h080;
    localparam logic [8:0] S_IR  = 9'h040;
    localparam logic [8:0] S_INC = 9'h020;
    localparam logic [8:0] S_LPC = 9'h010;
    localparam logic [8:0] S_LAC = 9'h008;
    localparam logic [8:0] S_WR  = 9'h004;
    localparam logic [8:0] S_DE  = 9'h002;
    localparam logic [8:0] S_HLT = 9'h001;
    localparam logic [8:0] S_0   = 9'h000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;

    always #5 clk = ~clk;

    logic        sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt;
    logic [15:0] instr_cnt;
    logic        sel4, mem_rd4, load_ir4, inc_pc4, load_pc4, load_ac4, mem_wr4, data_e4, halt4;
    logic [3:0]  instr_cnt4;
    logic [8:0]  w_str;

    cpu_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .mem_rd(mem_rd), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_ac(load_ac), .mem_wr(mem_wr), .data_e(data_e),
        .halt(halt), .instr_cnt(instr_cnt)
    );

    cpu_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel4), .mem_rd(mem_rd4), .load_ir(load_ir4), .inc_pc(inc_pc4),
        .load_pc(load_pc4), .load_ac(load_ac4), .mem_wr(mem_wr4), .data_e(data_e4),
        .halt(halt4), .instr_cnt(instr_cnt4)
    );

    assign w_str = {sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt};

    typedef struct {
        logic [8:0]  str;
        logic [15:0] cnt;
        int          tag;
    } exp_t;

    exp_t        q[$];
    exp_t        mx;
    int          n_chk = 0;
    int          n_err = 0;
    int          step  = 0;
    logic [15:0] exp_cnt = 16'd0;

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            n_chk++;
            if (w_str !== mx.str) begin
                n_err++;
                $display("FAIL strobes step %0d: got %b expected %b", mx.tag, w_str, mx.str);
            end
            n_chk++;
            if (instr_cnt !== mx.cnt) begin
                n_err++;
                $display("FAIL instr_cnt step %0d: got %0d expected %0d", mx.tag, instr_cnt, mx.cnt);
            end
            n_chk++;
            if (instr_cnt4 !== mx.cnt[3:0]) begin
                n_err++;
                $display("FAIL instr_cnt4 step %0d: got %0d expected %0d", mx.tag, instr_cnt4, mx.cnt[3:0]);
            end
        end
    end

    task automatic cyc(input logic r, input logic [2:0] op, input logic z, input logic [8:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        x.str  = e;
        x.cnt  = exp_cnt;
        x.tag  = step;
        step++;
        q.push_back(x);
    endtask

    task automatic fetch(input logic [2:0] op, input logic z);
        cyc(1'b0, op, z, S_SEL);
        cyc(1'b0, op, z, S_SEL | S_RD);
        cyc(1'b0, op, z, S_SEL | S_RD | S_IR);
        cyc(1'b0, op, z, S_SEL | S_RD | S_IR);
    endtask

    task automatic instr(input logic [2:0] op, input logic z,
                         input logic [8:0] e4, input logic [8:0] e5,
                         input logic [8:0] e6, input logic [8:0] e7);
        fetch(op, z);
        cyc(1'b0, op, z, e4);
        cyc(1'b0, op, z, e5);
        cyc(1'b0, op, z, e6);
        cyc(1'b0, op, z, e7);
        exp_cnt++;
    endtask

    task automatic alu(input logic [2:0] op, input logic z);
        instr(op, z, S_INC, S_RD, S_RD | S_LAC, S_RD | S_LAC);
    endtask

    initial begin
        @(posedge clk);
        // Reset held three cycles, then ADD
        repeat (3) cyc(1'b1, 3'd2, 1'b0, S_SEL);
        alu(3'd2, 1'b0);
        // STO
        instr(3'd6, 1'b0, S_INC, S_0, S_DE, S_WR | S_DE);
        // SKZ with zero=1, then zero=0
        instr(3'd1, 1'b1, S_INC, S_0, S_INC, S_0);
        instr(3'd1, 1'b0, S_INC, S_0, S_0, S_0);
        // JMP
        instr(3'd7, 1'b1, S_INC, S_0, S_LPC, S_INC | S_LPC);
`ifdef CTRL_HALT_LATCH_EN
        alu(3'd3, 1'b0);
`else
        // HLT without latch: one-cycle pulse, sequencing continues
        instr(3'd0, 1'b0, S_INC | S_HLT, S_0, S_0, S_0);
`endif
        alu(3'd4, 1'b1);
        alu(3'd5, 1'b0);
        alu(3'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            alu(3'(2 + (i % 4)), 1'(i % 2));
        end
        // 17 retired: 4-bit counter reads 1. Reset in OP_FETCH discards the instruction.
        fetch(3'd2, 1'b0);
        cyc(1'b0, 3'd2, 1'b0, S_INC);
        cyc(1'b1, 3'd2, 1'b0, S_SEL);
        exp_cnt = 16'd0;
        alu(3'd2, 1'b0);
        instr(3'd6, 1'b1, S_INC, S_0, S_DE, S_WR | S_DE);
`ifdef CTRL_HALT_LATCH_EN
        // Sticky halt: frozen with counter unchanged until reset
        fetch(3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0, S_INC | S_HLT);
        repeat (21) cyc(1'b0, 3'd0, 1'b0, S_HLT);
        cyc(1'b1, 3'd0, 1'b0, S_SEL);
        exp_cnt = 16'd0;
        alu(3'd2, 1'b0);
`endif
        @(negedge clk);
        #1;
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Instruction sequencer for the 8-bit accumulator CPU. It steps a fixed 8-phase cycle per instruction and decodes the 3-bit opcode and the accumulator zero flag into all datapath strobes. Its `sel` output drives the address `scale_mux` directly: 1 selects the PC address for instruction fetch, 0 selects the IR operand address. It also keeps a retired-instruction counter for bring-up and debug.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `opcode` input 3: IR opcode field. 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- `zero` input 1: accumulator-is-zero flag.
- `sel` output 1: address mux select. 1 = PC, 0 = IR address.
- `mem_rd` output 1: memory read enable.
- `load_ir` output 1: instruction register load.
- `inc_pc` output 1: program counter increment.
- `load_pc` output 1: program counter load (jump).
- `load_ac` output 1: accumulator load.
- `mem_wr` output 1: memory write strobe.
- `data_e` output 1: accumulator drives the data bus.
- `halt` output 1: CPU halted.
- `instr_cnt` output CNT_W: number of retired instructions, modulo 2^CNT_W.

## Operation
- 3-bit phase register, advancing one step per clock in this order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7). STORE wraps to INST_ADDR.
- Strobes are combinational decodes of phase, `opcode` and `zero`. ALUOP means opcode is ADD, AND, XOR or LDA.
- INST_ADDR: `sel`.
- INST_FETCH: `sel`, `mem_rd`.
- INST_LOAD and IDLE: `sel`, `mem_rd`, `load_ir`.
- OP_ADDR: `inc_pc`; `halt` if HLT.
- OP_FETCH: `mem_rd` if ALUOP.
- ALU_OP:
  - `mem_rd` and `load_ac` if ALUOP.
  - `inc_pc` if SKZ and `zero`.
  - `load_pc` if JMP.
  - `data_e` if STO.
- STORE:
  - `mem_rd` and `load_ac` if ALUOP.
  - `inc_pc` and `load_pc` if JMP.
  - `mem_wr` and `data_e` if STO.
- Every strobe not listed for a phase is 0.
- `opcode` and `zero` are sampled combinationally in every phase. They must be stable from INST_LOAD onward.
- `mem_wr` and `data_e` are never both driven by different instructions in the same cycle. `mem_wr` is 1 only if `data_e` is 1.
- `instr_cnt` increments by 1 on each STORE→INST_ADDR transition and wraps from all-ones to 0.

## Timing
- Reset: the phase register loads INST_ADDR and `instr_cnt` loads 0.
  - Halt latch clears (see Configuration).
  - Outputs while `rst`=1: `sel`=1, all other strobes 0, `halt`=0.
- Reset mid-instruction discards the instruction. The first edge with `rst`=0 enters INST_FETCH.
- One instruction takes exactly 8 cycles. Fetch to `load_ir` first high takes 2 cycles.
- Strobes change only after a clock edge. A strobe is asserted for the whole cycle of its phase.
- SKZ with `zero`=0: no `inc_pc` in ALU_OP. The PC advances once only.

## Configuration
- `CTRL_HALT_LATCH_EN` defined:
  - HLT in OP_ADDR sets a sticky halt flag on that edge.
  - The phase freezes at OP_FETCH and all strobes are held at 0.
  - `halt` stays 1 until `rst`.
  - `instr_cnt` stops.
- `CTRL_HALT_LATCH_EN` undefined:
  - `halt` is the combinational OP_ADDR pulse only, one cycle long.
  - Sequencing continues. HLT otherwise behaves as a NOP.

## Test plan
- Reset sequencing: hold `rst` 3 cycles, then release with opcode=ADD.
  - During reset: `sel`=1, all other strobes 0.
  - After release: phases 1..7 in order. `load_ac` high in cycles 6 and 7. `instr_cnt`=1 after 8 cycles.
- STO: opcode=6.
  - `data_e` high in ALU_OP and STORE.
  - `mem_wr` high in STORE only.
  - `mem_rd` low in phases 5–7.
- SKZ: opcode=1 with `zero`=1, then with `zero`=0.
  - `zero`=1: `inc_pc` pulses in OP_ADDR and ALU_OP.
  - `zero`=0: `inc_pc` pulses in OP_ADDR only.
- JMP: opcode=7.
  - `load_pc` high in ALU_OP and STORE.
  - `inc_pc` high in STORE.
  - `sel`=0 in phases 4–7.
- HLT: opcode=0.
  - With macro: `halt`=1 from the OP_ADDR edge onward, phase stuck. 20 further cycles leave `instr_cnt` unchanged. `rst` clears it.
  - Without macro: `halt` is a 1-cycle pulse and `instr_cnt` increments.
- Wrap: CNT_W=4, 17 instructions → `instr_cnt`=1. Assert `rst` in phase 5 → next cycle is phase 0 with counter 0.
